checksum_checker: RTL and testbench



---
 rtl/checksum_checker.sv | 130 +++++++++++++
 tb/tb_checksum_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/checksum_checker.sv
// Receive-side frame checksum checker.
// Accepts N_BYTES data bytes followed by one checksum byte over a valid/ready stream.
// A frame passes when the 8-bit sum of all data bytes plus the checksum byte is zero.
// Results, the frame's cycle count and saturating frame/failure counters stay registered
// until the next frame completes or reset.
module checksum_checker #(
  parameter int unsigned N_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  computed_chk,
  output logic [7:0]  received_chk,
  output logic [15:0] cycle_count,
  output logic [7:0]  frame_count,
  output logic [7:0]  fail_count
);

  typedef enum logic [2:0] {
    StIdle,
    StRecvData,
    StRecvChk,
    StCheck,
    StDone
  } state_e;

  localparam logic [7:0] LastIdx = 8'(N_BYTES - 1);

  state_e      state_q;
  logic [7:0]  sum_q;
  logic [7:0]  idx_q;
  logic [7:0]  chk_q;
  logic [15:0] cyc_q;

  logic [15:0] cyc_inc;
  logic [7:0]  frame_sum;
  logic        frame_ok;

  // Saturating cycle increment and the pass decision for the frame held in sum_q/chk_q
  always_comb begin
    cyc_inc   = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    frame_sum = sum_q + chk_q;
    frame_ok  = (frame_sum == 8'h00);
  end

  // Frame FSM with all outputs registered; in_ready/busy track the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sum_q        <= 8'h00;
      idx_q        <= 8'h00;
      chk_q        <= 8'h00;
      cyc_q        <= 16'h0000;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      computed_chk <= 8'h00;
      received_chk <= 8'h00;
      cycle_count  <= 16'h0000;
      frame_count  <= 8'h00;
      fail_count   <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            sum_q    <= 8'h00;
            idx_q    <= 8'h00;
            cyc_q    <= 16'h0000;
            state_q  <= StRecvData;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StRecvData: begin
          cyc_q <= cyc_inc;
          if (in_valid) begin
            sum_q <= sum_q + in_data;
            idx_q <= idx_q + 8'd1;
            if (idx_q == LastIdx) begin
              state_q <= StRecvChk;
            end
          end
        end
        StRecvChk: begin
          cyc_q <= cyc_inc;
          if (in_valid) begin
            chk_q    <= in_data;
            state_q  <= StCheck;
            in_ready <= 1'b0;
          end
        end
        StCheck: begin
          // The CHECK cycle itself counts toward the frame length
          cyc_q        <= cyc_inc;
          computed_chk <= ~sum_q + 8'd1;
          received_chk <= chk_q;
          pass         <= frame_ok;
          cycle_count  <= cyc_inc;
          if (frame_count != 8'hFF) begin
            frame_count <= frame_count + 8'd1;
          end
          if (!frame_ok && (fail_count != 8'hFF)) begin
            fail_count <= fail_count + 8'd1;
          end
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checksum_checker.sv
// Self-checking bench for checksum_checker: directed table, hand-written corner
// sequences, and randomized frames against an arithmetic reference model.
module tb_checksum_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  computed_chk;
  logic [7:0]  received_chk;
  logic [15:0] cycle_count;
  logic [7:0]  frame_count;
  logic [7:0]  fail_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference counters
  int m_frames = 0;
  int m_fails  = 0;

  checksum_checker #(.N_BYTES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .computed_chk (computed_chk),
    .received_chk (received_chk),
    .cycle_count  (cycle_count),
    .frame_count  (frame_count),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   chk;
    int           stall_pos;
    int           stall_len;
    int           chk_stall;
    bit           idle_junk;
    bit           mid_start;
    bit           exp_pass;
    logic [7:0]   exp_comp;
    int           exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame starting aligned #1 after a posedge in IDLE; returns aligned the same way.
  task automatic run_frame(input logic [127:0] d, input logic [7:0] c, input int stall_pos,
                           input int stall_len, input int chk_stall, input bit idle_junk,
                           input bit mid_start, input bit keep_start,
                           output bit got_done, output int lat);
    got_done = 1'b0;
    lat      = -1;
    if (idle_junk) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = d[8*i +: 8];
      if (mid_start && i == 3) start = 1'b1;
      @(posedge clk); #1;
      if (mid_start && i == 3 && !keep_start) start = 1'b0;
      if (i == stall_pos) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        repeat (stall_len) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'hDD;
    repeat (chk_stall) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk); #1;
    // Keep junk on the bus; it must be ignored outside the receive states
    in_data = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        lat      = k + 1;
        break;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic model_frame(input logic [127:0] d, input logic [7:0] c, output bit p,
                             output logic [7:0] comp);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(d[8*i +: 8]);
    comp = 8'((256 - (s % 256)) % 256);
    p    = ((s + int'(c)) % 256) == 0;
    m_frames = (m_frames == 255) ? 255 : m_frames + 1;
    if (!p) m_fails = (m_fails == 255) ? 255 : m_fails + 1;
  endtask

  task automatic check_results(input string tag, input bit gd, input int lat, input bit p,
                               input logic [7:0] comp, input logic [7:0] c, input int cyc);
    check({tag, "_done"}, 32'(gd), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_pass"}, 32'(pass), 32'(p));
    check({tag, "_computed"}, 32'(computed_chk), 32'(comp));
    check({tag, "_received"}, 32'(received_chk), 32'(c));
    check({tag, "_cycles"}, 32'(cycle_count), 32'(cyc));
    check({tag, "_frames"}, 32'(frame_count), 32'(m_frames));
    check({tag, "_fails"}, 32'(fail_count), 32'(m_fails));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_computed"}, 32'(computed_chk), 32'd0);
    check({tag, "_received"}, 32'(received_chk), 32'd0);
    check({tag, "_cycles"}, 32'(cycle_count), 32'd0);
    check({tag, "_frames"}, 32'(frame_count), 32'd0);
    check({tag, "_fails"}, 32'(fail_count), 32'd0);
  endtask

  initial begin
    vec_t         vecs[5];
    logic [127:0] seq;
    bit           gd;
    int           lat;
    bit           p;
    logic [7:0]   comp;
    logic [127:0] rd;
    logic [7:0]   rc;
    int           sp, sl, cs;
    bit           saw_done;

    seq = 128'h100F0E0D0C0B0A090807060504030201;
    vecs[0] = '{128'h0, 8'h00, -1, 0, 0, 1'b0, 1'b0, 1'b1, 8'h00, 18};
    vecs[1] = '{seq, 8'h78, -1, 0, 0, 1'b0, 1'b0, 1'b1, 8'h78, 18};
    vecs[2] = '{seq, 8'h77, -1, 0, 0, 1'b0, 1'b0, 1'b0, 8'h78, 18};
    vecs[3] = '{seq, 8'h78, 4, 3, 2, 1'b0, 1'b0, 1'b1, 8'h78, 23};
    vecs[4] = '{seq, 8'h78, -1, 0, 0, 1'b1, 1'b1, 1'b1, 8'h78, 18};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].data, vecs[v].chk, vecs[v].stall_pos, vecs[v].stall_len,
                vecs[v].chk_stall, vecs[v].idle_junk, vecs[v].mid_start, 1'b0, gd, lat);
      model_frame(vecs[v].data, vecs[v].chk, p, comp);
      check("vec_model_pass", 32'(p), 32'(vecs[v].exp_pass));
      check_results($sformatf("vec%0d", v), gd, lat, vecs[v].exp_pass, vecs[v].exp_comp,
                    vecs[v].chk, vecs[v].exp_cyc);
      check("vec_idle_after", 32'(busy), 32'd0);
    end

    // start held high: next frame begins from IDLE on the cycle after DONE
    run_frame(seq, 8'h78, -1, 0, 0, 1'b0, 1'b0, 1'b1, gd, lat);
    model_frame(seq, 8'h78, p, comp);
    check_results("held", gd, lat, p, comp, 8'h78, 18);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_ready", 32'(in_ready), 32'd1);

    // Feed 8 bytes, then reset asynchronously mid-frame
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midreset_no_done", 32'(saw_done), 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    m_frames = 0;
    m_fails  = 0;
    @(posedge clk); #1;
    run_frame(seq, 8'h78, -1, 0, 0, 1'b0, 1'b0, 1'b0, gd, lat);
    model_frame(seq, 8'h78, p, comp);
    check_results("postreset", gd, lat, p, comp, 8'h78, 18);
    check("postreset_frames", 32'(frame_count), 32'd1);

    // Randomized frames; enough of them to drive frame_count into saturation
    for (int f = 0; f < 260; f++) begin
      for (int i = 0; i < 16; i++) rd[8*i +: 8] = 8'($urandom_range(255, 0));
      rc = 8'($urandom_range(255, 0));
      if ($urandom_range(1, 0) == 1) begin
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(rd[8*i +: 8]);
        rc = 8'((256 - (s % 256)) % 256);
      end
      sp = ($urandom_range(1, 0) == 1) ? int'($urandom_range(15, 0)) : -1;
      sl = int'($urandom_range(3, 0));
      cs = int'($urandom_range(2, 0));
      run_frame(rd, rc, sp, sl, cs, 1'b0, ($urandom_range(3, 0) == 0), 1'b0, gd, lat);
      model_frame(rd, rc, p, comp);
      check_results($sformatf("rand%0d", f), gd, lat, p, comp, rc,
                    18 + cs + ((sp >= 0) ? sl : 0));
    end
    check("saturated_frames", 32'(frame_count), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
